// File: rtl/aes_iter_core.sv
// -----------------------------------------------------------------------------
// aes_iter_core
//
// Iterative AES engine: one full round per clock, encrypt or decrypt chosen per
// block, AES-128/192/256 selected by parameter NK (4, 6 or 8 key words).
// The caller supplies the whole expanded key schedule; it must stay stable
// while busy is high. Blocks are not overlapped: a new block is accepted only
// in IDLE, and a finished result is held until the consumer takes it.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   round_keys  expanded schedule, round key i at [128*i +: 128]
//   in_valid    block offered          in_ready   core can accept (IDLE only)
//   mode        0 = encrypt, 1 = decrypt, sampled on accept
//   data_in     input block, byte 0 at [127:120], column-major
//   out_valid   result available       out_ready  consumer takes the result
//   data_out    result block, held while out_valid && !out_ready
//   busy        high from accept until the result is taken
//
// Optional build macro AES_ITER_ROUNDTAP_EN adds debug taps:
//   dbg_round   current round counter
//   dbg_state   registered round state
// -----------------------------------------------------------------------------
module aes_iter_core #(
   parameter int NK = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [128*(NK+7)-1:0]       round_keys,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        mode,
   input  logic [127:0]                data_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [127:0]                data_out,
   output logic                        busy
`ifdef AES_ITER_ROUNDTAP_EN
   ,
   output logic [$clog2(NK+7)-1:0]     dbg_round,
   output logic [127:0]                dbg_state
`endif
);

   localparam int NR  = NK + 6;
   localparam int RCW = $clog2(NR + 1);

   if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
      $error("aes_iter_core: NK must be 4, 6 or 8");
   end

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

   // ---------------------------------------------------------------- GF(2^8)
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] sq, r;
      sq = a;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
      return (a << n) | (a >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
   endfunction

   // ------------------------------------------------------- round primitives
   function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      for (int b = 0; b < 16; b++)
         o[8*b +: 8] = inv ? inv_sbox(s[8*b +: 8]) : sbox(s[8*b +: 8]);
      return o;
   endfunction

   // Byte (row r, column c) lives at [127-8*(4*c+r) -: 8].
   function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      int src;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            src = inv ? (c - r + 4) % 4 : (c + r) % 4;
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
         end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      logic [7:0]   a [4];
      logic [7:0]   m [4];
      if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = gmul(m[0], a[r])         ^ gmul(m[1], a[(r+1)%4]) ^
                                    gmul(m[2], a[(r+2)%4])   ^ gmul(m[3], a[(r+3)%4]);
      end
      return o;
   endfunction

   // ------------------------------------------------------------- datapath
   fsm_t           fsm;
   logic [RCW-1:0] rc;
   logic [127:0]   state;
   logic           mode_q;

   logic [127:0]   rk [NR+1];
   logic [RCW-1:0] key_idx;
   logic [127:0]   rk_sel, k0;
   logic [127:0]   enc_sr, enc_full, enc_last, dec_ark, dec_full;
   logic [127:0]   next_round, next_final;

   always_comb begin
      for (int i = 0; i <= NR; i++) rk[i] = round_keys[128*i +: 128];
   end

   // Decrypt walks the schedule backwards; in FINAL rc == NR, so the same
   // expression yields rk[NR] for encrypt and rk[0] for decrypt.
   assign key_idx = mode_q ? RCW'(NR) - rc : rc;
   assign rk_sel  = rk[key_idx];
   assign k0      = mode ? rk[NR] : rk[0];

   // NOTE: every signal of this block is assigned on every pass, so no latch can form.
   always_comb begin
      enc_sr     = shift_rows(sub_bytes(state, 1'b0), 1'b0);
      enc_full   = mix_columns(enc_sr, 1'b0) ^ rk_sel;
      enc_last   = enc_sr ^ rk_sel;
      dec_ark    = sub_bytes(shift_rows(state, 1'b1), 1'b1) ^ rk_sel;
      dec_full   = mix_columns(dec_ark, 1'b1);
      next_round = mode_q ? dec_full : enc_full;
      next_final = mode_q ? dec_ark  : enc_last;
   end

   // ------------------------------------------------------------------ FSM
   // NOTE: all registers use non-blocking assignments so each one samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         fsm       <= IDLE;
         rc        <= '0;
         state     <= '0;
         mode_q    <= 1'b0;
         data_out  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         unique case (fsm)
            IDLE: begin
               if (in_valid) begin
                  mode_q   <= mode;
                  state    <= data_in ^ k0;
                  rc       <= RCW'(1);
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  fsm      <= ROUND;
               end
            end
            ROUND: begin
               state <= next_round;
               rc    <= rc + RCW'(1);
               if (rc == RCW'(NR - 1)) fsm <= FINAL;
            end
            FINAL: begin
               state     <= next_final;
               data_out  <= next_final;
               out_valid <= 1'b1;
               fsm       <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  rc        <= '0;
                  fsm       <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

`ifdef AES_ITER_ROUNDTAP_EN
   assign dbg_round = rc;
   assign dbg_state = state;
`endif

endmodule

// File: tb/tb_aes_iter_core.sv
// -----------------------------------------------------------------------------
// tb_aes_iter_core
//
// Drives three cores (NK = 4, 6, 8) from one clock and reset. Expected values
// come from the FIPS-197 known answers and from a byte-level AES model kept
// in this file (S-box built by brute-force inversion, key expansion in words).
// -----------------------------------------------------------------------------
module tb_aes_iter_core;

   localparam bit [255:0] KEY    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam bit [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam bit [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam bit [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam bit [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [128*15-1:0]    rk_bus    [3];
   logic                 in_valid  [3];
   logic                 in_ready  [3];
   logic                 mode      [3];
   logic [127:0]         data_in   [3];
   logic                 out_valid [3];
   logic                 out_ready [3];
   logic [127:0]         data_out  [3];
   logic                 busy      [3];
`ifdef AES_ITER_ROUNDTAP_EN
   logic [3:0]           dbg_round [3];
   logic [127:0]         dbg_state [3];
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   aes_iter_core #(.NK(4)) u_dut4 (
      .clk(clk), .reset(reset), .round_keys(rk_bus[0][128*11-1:0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .mode(mode[0]), .data_in(data_in[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .data_out(data_out[0]), .busy(busy[0])
`ifdef AES_ITER_ROUNDTAP_EN
      , .dbg_round(dbg_round[0]), .dbg_state(dbg_state[0])
`endif
   );

   aes_iter_core #(.NK(6)) u_dut6 (
      .clk(clk), .reset(reset), .round_keys(rk_bus[1][128*13-1:0]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .mode(mode[1]), .data_in(data_in[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .data_out(data_out[1]), .busy(busy[1])
`ifdef AES_ITER_ROUNDTAP_EN
      , .dbg_round(dbg_round[1]), .dbg_state(dbg_state[1])
`endif
   );

   aes_iter_core #(.NK(8)) u_dut8 (
      .clk(clk), .reset(reset), .round_keys(rk_bus[2][128*15-1:0]),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .mode(mode[2]), .data_in(data_in[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .data_out(data_out[2]), .busy(busy[2])
`ifdef AES_ITER_ROUNDTAP_EN
      , .dbg_round(dbg_round[2]), .dbg_state(dbg_state[2])
`endif
   );

   // ------------------------------------------------------------ reference
   bit [7:0] sb  [256];
   bit [7:0] isb [256];

   function automatic bit [7:0] mul(input bit [7:0] a, input bit [7:0] b);
      int x, y, p;
      x = a; y = b; p = 0;
      while (y != 0) begin
         if ((y & 1) != 0) p ^= x;
         x <<= 1;
         if ((x & 'h100) != 0) x ^= 'h11b;
         y >>= 1;
      end
      return p[7:0];
   endfunction

   function automatic bit [31:0] subw(input bit [31:0] t);
      return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
   endfunction

   // Key bytes taken from the top of 'key'; round key r at [128*r +: 128].
   function automatic bit [128*15-1:0] expand(input int nk, input bit [255:0] key);
      bit [31:0]         w [60];
      bit [31:0]         t;
      bit [7:0]          rcon;
      bit [128*15-1:0]   bus;
      rcon = 8'h01;
      bus  = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nk+7); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = mul(rcon, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < nk+7; r++) bus[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return bus;
   endfunction

   function automatic bit [127:0] model(input int nk, input bit [255:0] key,
                                        input bit [127:0] blk, input bit dec);
      bit [128*15-1:0] ks;
      bit [7:0]        s [16];
      bit [7:0]        t [16];
      bit [7:0]        a0, a1, a2, a3;
      bit [127:0]      res;
      int              nr, rnd;
      nr = nk + 6;
      ks = expand(nk, key);
      for (int b = 0; b < 16; b++) s[b] = blk[127-8*b -: 8] ^ ks[128*(dec ? nr : 0) + 127 - 8*b -: 8];
      for (int i = 1; i <= nr; i++) begin
         rnd = dec ? nr - i : i;
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               if (!dec) t[r+4*c] = sb[s[r+4*((c+r)%4)]];
               else      t[r+4*((c+r)%4)] = isb[s[r+4*c]];
         s = t;
         if (dec) for (int b = 0; b < 16; b++) s[b] ^= ks[128*rnd + 127 - 8*b -: 8];
         if (i < nr) begin
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++) begin
                  a0 = s[4*c+r]; a1 = s[4*c+(r+1)%4]; a2 = s[4*c+(r+2)%4]; a3 = s[4*c+(r+3)%4];
                  t[4*c+r] = dec ? (mul(8'h0e, a0) ^ mul(8'h0b, a1) ^ mul(8'h0d, a2) ^ mul(8'h09, a3))
                                 : (mul(8'h02, a0) ^ mul(8'h03, a1) ^ a2 ^ a3);
               end
            s = t;
         end
         if (!dec) for (int b = 0; b < 16; b++) s[b] ^= ks[128*rnd + 127 - 8*b -: 8];
      end
      for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
      return res;
   endfunction

   // ---------------------------------------------------------------- helpers
   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Offers one block with out_ready high, scribbles on mode/data_in while
   // busy, and reports the result plus latency counted with the accept edge
   // as edge 1.
   task automatic run_block(input int k, input bit m, input bit [127:0] din,
                            output logic [127:0] got, output int lat);
      int n;
      @(negedge clk);
      in_valid[k] = 1'b1; mode[k] = m; data_in[k] = din; out_ready[k] = 1'b1;
      n = 0;
      while (!in_ready[k] && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      in_valid[k] = 1'b0;
      mode[k]     = 1'($urandom_range(0, 1));
      data_in[k]  = {$urandom(), $urandom(), $urandom(), $urandom()};
      lat = 1;
      while (!out_valid[k] && lat < 40) begin @(negedge clk); lat++; end
      got = data_out[k];
      @(negedge clk);
   endtask

   typedef struct {
      int         k;
      bit         dec;
      bit [127:0] din;
      bit [127:0] exp;
   } vec_t;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ------------------------------------------------------------------ test
   initial begin
      vec_t        vecs [6];
      logic [127:0] got;
      int          lat, n, nr;
      bit [255:0]  rkey;
      bit [127:0]  rblk;
      bit          rdec;
      int          acc [$];
      logic [127:0] res [$];
      bit          acc_now;

      vecs[0] = '{0, 1'b0, PT,    CT128};
      vecs[1] = '{1, 1'b0, PT,    CT192};
      vecs[2] = '{2, 1'b0, PT,    CT256};
      vecs[3] = '{0, 1'b1, CT128, PT};
      vecs[4] = '{1, 1'b1, CT192, PT};
      vecs[5] = '{2, 1'b1, CT256, PT};

      for (int x = 0; x < 256; x++) begin
         bit [7:0] inv, aff, c;
         inv = 8'h00;
         c   = 8'h63;
         for (int y = 1; y < 256; y++) if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            aff[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sb[x]    = aff;
         isb[aff] = 8'(x);
      end

      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid[k] = 1'b0; mode[k] = 1'b0; data_in[k] = '0; out_ready[k] = 1'b1;
         rk_bus[k]   = expand(4 + 2*k, KEY);
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state of every core.
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset_in_ready[%0d]", k),  in_ready[k],  1);
         check($sformatf("reset_out_valid[%0d]", k), out_valid[k], 0);
         check($sformatf("reset_busy[%0d]", k),      busy[k],      0);
         check($sformatf("reset_data_out[%0d]", k),  data_out[k],  0);
      end

      // Known-answer vectors, both directions, all key sizes.
      for (int v = 0; v < 6; v++) begin
         nr = 10 + 2*vecs[v].k;
         run_block(vecs[v].k, vecs[v].dec, vecs[v].din, got, lat);
         check($sformatf("kat_data[%0d]", v), got, vecs[v].exp);
         check($sformatf("kat_latency[%0d]", v), 128'(lat), 128'(nr + 1));
      end

      // Random keys, blocks and modes against the model.
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 6; j++) begin
            rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
            rblk = {$urandom(), $urandom(), $urandom(), $urandom()};
            rdec = 1'($urandom_range(0, 1));
            rk_bus[k] = expand(4 + 2*k, rkey);
            run_block(k, rdec, rblk, got, lat);
            check($sformatf("rand_data[%0d.%0d]", k, j), got, model(4 + 2*k, rkey, rblk, rdec));
            check($sformatf("rand_latency[%0d.%0d]", k, j), 128'(lat), 128'(11 + 2*k));
         end
      end

      // Backpressure: hold the result for 20 cycles while inputs churn.
      rk_bus[0] = expand(4, KEY);
      @(negedge clk);
      out_ready[0] = 1'b0; in_valid[0] = 1'b1; mode[0] = 1'b0; data_in[0] = PT;
      @(negedge clk);
      in_valid[0] = 1'b0;
      n = 0;
      while (!out_valid[0] && n < 40) begin @(negedge clk); n++; end
      check("bp_valid", out_valid[0], 1);
      check("bp_data", data_out[0], CT128);
      for (int i = 0; i < 20; i++) begin
         in_valid[0] = 1'($urandom_range(0, 1));
         mode[0]     = 1'($urandom_range(0, 1));
         data_in[0]  = {$urandom(), $urandom(), $urandom(), $urandom()};
         @(negedge clk);
         check($sformatf("bp_hold_data[%0d]", i),  data_out[0],  CT128);
         check($sformatf("bp_hold_ready[%0d]", i), in_ready[0],  0);
         check($sformatf("bp_hold_valid[%0d]", i), out_valid[0], 1);
      end
      in_valid[0] = 1'b0; out_ready[0] = 1'b1;
      @(negedge clk);
      check("bp_release_ready", in_ready[0],  1);
      check("bp_release_valid", out_valid[0], 0);
      check("bp_release_busy",  busy[0],      0);

      // Reset while rc = 5: partial block is discarded.
      in_valid[0] = 1'b1; mode[0] = 1'b0; data_in[0] = PT;
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (4) @(negedge clk);
`ifdef AES_ITER_ROUNDTAP_EN
      check("mid_dbg_round", dbg_round[0], 5);
`endif
      check("mid_busy_before", busy[0], 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_out_valid", out_valid[0], 0);
      check("mid_data_out",  data_out[0],  0);
      check("mid_in_ready",  in_ready[0],  1);
      check("mid_busy",      busy[0],      0);
      run_block(0, 1'b0, PT, got, lat);
      check("mid_after_data", got, CT128);
      check("mid_after_latency", 128'(lat), 128'(11));

      // Back-to-back on NK=6: encrypt then decrypt, in_valid held high.
      rk_bus[1] = expand(6, KEY);
      @(negedge clk);
      in_valid[1] = 1'b1; mode[1] = 1'b0; data_in[1] = PT; out_ready[1] = 1'b1;
      for (int i = 0; i < 34; i++) begin
         if (out_valid[1]) res.push_back(data_out[1]);
         acc_now = in_valid[1] && in_ready[1];
         if (acc_now) acc.push_back(i);
         @(negedge clk);
         if (acc_now && acc.size() == 1) begin
            mode[1] = 1'b1; data_in[1] = CT192;
         end else if (acc_now) begin
            in_valid[1] = 1'b0;
         end
      end
      in_valid[1] = 1'b0;
      check("b2b_accepts", 128'(acc.size()), 128'(2));
      check("b2b_spacing", 128'(acc.size() >= 2 ? acc[1] - acc[0] : -1), 128'(14));
      check("b2b_results", 128'(res.size()), 128'(2));
      check("b2b_enc", res.size() >= 1 ? res[0] : 'x, CT192);
      check("b2b_dec", res.size() >= 2 ? res[1] : 'x, PT);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
